// File: rtl/sticky_run_detector_if.sv
// Channel input/status bundle for sticky_run_detector.
// The master drives the channel inputs and clears; the slave returns flags and the interrupt.
interface sticky_run_detector_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 2
);
    logic [CHANNELS*WIDTH-1:0] a;
    logic [CHANNELS-1:0]       clr;
    logic [CHANNELS-1:0]       flag_n;
    logic                      any_n;
    logic                      irq;

    modport master (
        output a,
        output clr,
        input  flag_n,
        input  any_n,
        input  irq
    );

    modport slave (
        input  a,
        input  clr,
        output flag_n,
        output any_n,
        output irq
    );
endinterface

// File: rtl/sticky_run_detector.sv
// Multi-channel run detector: a channel flags once its reduced slice matches for RUN_LEN
// consecutive cycles; flags are optionally sticky and drive active-low status plus an irq pulse.
module sticky_run_detector #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned RUN_LEN   = 2,
    parameter bit          REDUCE_OR = 1'b0,
    parameter bit          STICKY    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sticky_run_detector_if.slave  bus_io
);
    localparam int unsigned CntW = $clog2(RUN_LEN + 1);
    localparam logic [CntW-1:0] RunMax = CntW'(RUN_LEN);
    localparam logic [CntW-1:0] HitThr = CntW'(RUN_LEN - 1);

    logic [CntW-1:0]     cnt_q [CHANNELS];
    logic [CntW-1:0]     cnt_d [CHANNELS];
    logic [CHANNELS-1:0] match;
    logic [CHANNELS-1:0] hit;
    logic [CHANNELS-1:0] flag_q, flag_d;
    logic                irq_q, irq_d;

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            logic [WIDTH-1:0] slice;
            slice    = bus_io.a[k*WIDTH +: WIDTH];
            match[k] = REDUCE_OR ? (|slice) : (&slice);
            // The current matching cycle completes the run when the count is one short.
            hit[k]   = match[k] & (cnt_q[k] >= HitThr);
            if (!match[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == RunMax) begin
                cnt_d[k] = RunMax;
            end else begin
                cnt_d[k] = cnt_q[k] + CntW'(1);
            end
        end
    end

    always_comb begin
        flag_d = hit;
        if (STICKY) begin
            // A fresh hit overrides a clear arriving in the same cycle.
            flag_d = hit | (flag_q & ~bus_io.clr);
        end
        irq_d = |(hit & ~flag_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                cnt_q[k] <= '0;
            end
            flag_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            flag_q <= flag_d;
            irq_q  <= irq_d;
        end
    end

    assign bus_io.flag_n = ~flag_q;
    assign bus_io.any_n  = ~(|flag_q);
    assign bus_io.irq    = irq_q;
endmodule

// File: tb/tb_sticky_run_detector.sv
// Bench for sticky_run_detector: three configurations share one clock; a spec model
// predicts each edge, pushes the expected outputs and each test pops and compares them.
module tb_sticky_run_detector;
    logic clk;
    logic rst_n;

    sticky_run_detector_if #(.CHANNELS(4), .WIDTH(2)) bus0 ();
    sticky_run_detector_if #(.CHANNELS(3), .WIDTH(4)) bus1 ();
    sticky_run_detector_if #(.CHANNELS(4), .WIDTH(2)) bus2 ();

    // Defaults: 4 ch, 2 bits, run of 2, AND, sticky.
    sticky_run_detector dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus0)
    );

    sticky_run_detector #(
        .CHANNELS (3),
        .WIDTH    (4),
        .RUN_LEN  (5),
        .REDUCE_OR(1'b1),
        .STICKY   (1'b1)
    ) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus1)
    );

    sticky_run_detector #(
        .RUN_LEN (1),
        .STICKY  (1'b0)
    ) dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][3:0] cnt;
        logic [3:0]      flag;
        logic            irq;
    } mstate_t;

    localparam logic [16:0] ResetVec = {4'hF, 1'b1, 1'b0, 3'h7, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0};

    mstate_t     s0, s1, s2;
    logic [16:0] sb_q [$];
    logic [16:0] exp_v;
    int          n_vec;
    int          n_fail;

    function automatic mstate_t model_next(mstate_t s, int ch, int w, int rl, bit orr,
                                           bit sticky, logic [15:0] a, logic [3:0] clr);
        mstate_t     n;
        logic [15:0] mask;
        logic [15:0] sl;
        bit          m;
        bit          h;
        n     = s;
        n.irq = 1'b0;
        mask  = (16'd1 << w) - 16'd1;
        for (int k = 0; k < ch; k++) begin
            sl = (a >> (k * w)) & mask;
            m  = orr ? (sl != 16'd0) : (sl == mask);
            h  = m && (int'(s.cnt[k]) >= rl - 1);
            if (!m) n.cnt[k] = 4'd0;
            else if (int'(s.cnt[k]) >= rl) n.cnt[k] = 4'(rl);
            else n.cnt[k] = s.cnt[k] + 4'd1;
            n.flag[k] = sticky ? (h | (s.flag[k] & ~clr[k])) : h;
            if (h && !s.flag[k]) n.irq = 1'b1;
        end
        return n;
    endfunction

    function automatic logic [16:0] expect_vec();
        return {~s0.flag, ~(|s0.flag), s0.irq, ~s1.flag[2:0], ~(|s1.flag), s1.irq,
                ~s2.flag, ~(|s2.flag), s2.irq};
    endfunction

    function automatic logic [16:0] observe();
        return {bus0.flag_n, bus0.any_n, bus0.irq, bus1.flag_n, bus1.any_n, bus1.irq,
                bus2.flag_n, bus2.any_n, bus2.irq};
    endfunction

    // Predict the next edge for all three DUTs, queue it, then let the edge happen.
    task automatic tick();
        s0 = model_next(s0, 4, 2, 2, 1'b0, 1'b1, 16'(bus0.a), bus0.clr);
        s1 = model_next(s1, 3, 4, 5, 1'b1, 1'b1, 16'(bus1.a), 4'(bus1.clr));
        s2 = model_next(s2, 4, 2, 1, 1'b0, 1'b0, 16'(bus2.a), bus2.clr);
        sb_q.push_back(expect_vec());
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        bus0.a = '0; bus0.clr = '0;
        bus1.a = '0; bus1.clr = '0;
        bus2.a = '0; bus2.clr = '0;
    endtask

    task automatic test_reset();
        zero_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (observe() !== ResetVec) begin
            n_fail++;
            $display("FAIL reset_async: got %b want %b", observe(), ResetVec);
        end
        s0 = '0; s1 = '0; s2 = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (observe() !== ResetVec) begin
            n_fail++;
            $display("FAIL reset_release: got %b want %b", observe(), ResetVec);
        end
    endtask

    task automatic test_basic_run();
        logic [7:0] seq [7] = '{8'h03, 8'h00, 8'h03, 8'h03, 8'h00, 8'h00, 8'h00};
        for (int c = 0; c < 7; c++) begin
            bus0.a = seq[c];
            tick();
            exp_v = sb_q.pop_front();
            n_vec++;
            if (observe() !== exp_v) begin
                n_fail++;
                $display("FAIL basic_run cycle %0d: got %b want %b", c, observe(), exp_v);
            end
        end
    endtask

    task automatic test_counter_reset();
        logic [7:0] seq [6] = '{8'h0C, 8'h04, 8'h0C, 8'h0C, 8'h00, 8'h00};
        for (int c = 0; c < 6; c++) begin
            bus0.a = seq[c];
            tick();
            exp_v = sb_q.pop_front();
            n_vec++;
            if (observe() !== exp_v) begin
                n_fail++;
                $display("FAIL counter_reset cycle %0d: got %b want %b", c, observe(), exp_v);
            end
        end
    endtask

    task automatic test_sticky_clear();
        logic [7:0] a_seq   [9] = '{8'h00, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h00, 8'h00, 8'h00};
        logic [3:0] clr_seq [9] = '{4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h3, 4'h0};
        for (int c = 0; c < 9; c++) begin
            bus0.a   = a_seq[c];
            bus0.clr = clr_seq[c];
            tick();
            exp_v = sb_q.pop_front();
            n_vec++;
            if (observe() !== exp_v) begin
                n_fail++;
                $display("FAIL sticky_clear cycle %0d: got %b want %b", c, observe(), exp_v);
            end
        end
        bus0.clr = '0;
    endtask

    task automatic test_wide_or();
        // 4 short, release, 5 to flag, then hold with clr high so a counter wrap would show.
        for (int c = 0; c < 32; c++) begin
            bus1.a   = ((c < 4) || (c >= 5 && c < 25)) ? 12'h100 : 12'h000;
            bus1.clr = ((c >= 11 && c < 25) || c == 25) ? 3'b100 : 3'b000;
            tick();
            exp_v = sb_q.pop_front();
            n_vec++;
            if (observe() !== exp_v) begin
                n_fail++;
                $display("FAIL wide_or cycle %0d: got %b want %b", c, observe(), exp_v);
            end
        end
        bus1.clr = '0;
    endtask

    task automatic test_nonsticky();
        for (int c = 0; c < 10; c++) begin
            bus2.a   = c[0] ? 8'h00 : 8'hFF;
            bus2.clr = 4'($urandom_range(0, 15));
            tick();
            exp_v = sb_q.pop_front();
            n_vec++;
            if (observe() !== exp_v) begin
                n_fail++;
                $display("FAIL nonsticky cycle %0d: got %b want %b", c, observe(), exp_v);
            end
        end
        bus2.clr = '0;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            bus0.a   = 8'($urandom);
            bus1.a   = 12'($urandom) & 12'h111;
            bus2.a   = 8'($urandom);
            bus0.clr = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            bus1.clr = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'h0;
            bus2.clr = 4'($urandom);
            tick();
            exp_v = sb_q.pop_front();
            n_vec++;
            if (observe() !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %b want %b", c, observe(), exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        zero_inputs();
        bus0.a = 8'hFF;
        bus1.a = 12'hFFF;
        tick();
        exp_v = sb_q.pop_front();
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (observe() !== ResetVec) begin
            n_fail++;
            $display("FAIL reset_mid_run: got %b want %b", observe(), ResetVec);
        end
        zero_inputs();
        s0 = '0; s1 = '0; s2 = '0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Counters must restart: one matching cycle alone cannot flag.
        for (int c = 0; c < 3; c++) begin
            bus0.a = 8'hFF;
            tick();
            exp_v = sb_q.pop_front();
            n_vec++;
            if (observe() !== exp_v) begin
                n_fail++;
                $display("FAIL resume_run cycle %0d: got %b want %b", c, observe(), exp_v);
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        s0 = '0; s1 = '0; s2 = '0;
        test_reset();
        test_basic_run();
        test_counter_reset();
        test_sticky_clear();
        test_wide_or();
        test_nonsticky();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
